mac_tile_db: RTL and testbench
==============================

# mac_tile_db

Second-generation systolic MAC tile for the ECE284 array. It keeps weight-stationary (WS) and output-stationary (OS) operation on one tile and adds three things:
- double-buffered (ping-pong) weights, so the next kernel loads while the current one computes;
- a shift-chain drain for OS accumulators;
- optional saturating accumulation with a sticky overflow flag.

Tiles abut west→east (activations, instructions) and north→south (psums or OS weights).

## Interface
Parameters:
- bw, 4: activation/weight width. Activations are unsigned; weights are two's-complement signed.
- psum_bw, 16: psum/accumulator width, signed; must be ≥ 2*bw+1.
- sat, 1: 1 = saturate the accumulator to the signed psum_bw range; 0 = wrap modulo 2^psum_bw.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low (0 = reset, sampled on the rising edge of clk).
- sel_mode  in  1  0 = WS, 1 = OS.
- in_w  in  bw  activation (WS/OS) or kernel weight (WS load) from the west.
- out_e  out  bw  registered activation to the east.
- inst_w  in  3  [0] kernel load, [1] execute, [2] swap (WS) / drain (OS).
- inst_e  out  3  registered instruction to the east.
- in_n  in  psum_bw  psum (WS), weight in [bw-1:0] (OS exec), or drain data (OS drain).
- out_s  out  psum_bw  psum (WS), zero-extended weight (OS exec), or accumulator (OS drain).
- valid_s  out  1  registered; out_s carries a psum (WS exec) or drained accumulator (OS drain).
- ovf  out  1  sticky overflow flag; cleared only by reset or a mode change.

## Operation
State:
- a_q: activation register.
- w_act, w_sh: active and shadow weight banks.
- sh_full: shadow bank holds a weight.
- c_q: registered in_n.
- acc_q: OS accumulator.
- inst_q: instruction register.
- mode_q: registered sel_mode.
- ovf.

Activation path:
- a_q <= in_w when inst_w[0] or inst_w[1] is set; otherwise it holds.
- out_e = a_q.

Instruction path:
- inst_q <= inst_w, with one exception. In WS, a load beat absorbed by this tile (sh_full=0) is forwarded as inst_q[0]=0.
- inst_e = inst_q.

WS mode:
- Load (inst_w[0]):
  - If sh_full=0: w_sh <= in_w, sh_full <= 1, and the beat is absorbed.
  - Otherwise the beat passes east unchanged.
- Swap (inst_w[2]):
  - w_act <= w_sh, sh_full <= 0; the swap is forwarded east.
  - Swap with sh_full=0 still copies w_sh (stale) and is legal.
- Load and swap in the same cycle:
  - w_act takes the old w_sh.
  - w_sh takes in_w; sh_full stays 1; the load is absorbed.
- Execute: c_q <= in_n every cycle; out_s = c_q + signed(a_q) × w_act, where a_q is zero-extended.
- Execute arithmetic:
  - The product is computed at 2*bw+1 bits and sign-extended to psum_bw.
  - The addition saturates or wraps according to sat.
  - ovf is set if saturation or wrap occurs.
- valid_s <= inst_w[1].

OS mode:
- Weight input: w_act <= in_n[bw-1:0] when inst_w[1]=1.
- Weight output: out_s = {zeros, w_act}.
- Execute:
  - acc_q <= acc_q + a_q_next × w_next, where a_q_next and w_next are the values being registered this cycle, i.e. in_w and in_n[bw-1:0].
  - Saturate or wrap per sat; ovf is sticky.
- Drain (inst_w[2]):
  - out_s = acc_q, acc_q <= in_n, valid_s <= 1.
  - A column of R tiles with the top in_n tied to 0 empties bottom-first in R drain cycles and ends with every acc_q = 0.
- Execute and drain asserted together: drain wins and the execute is ignored for accumulation.
- inst_w[0] is ignored in OS except for enabling a_q.

Mode change:
- mode_q != sel_mode is detected on a clock edge.
- On the next edge: acc_q, w_act, w_sh, sh_full, ovf and c_q are cleared, and inst_q is forced to 0 that cycle.
- Mode changes are legal only with inst_w = 0; behaviour otherwise is the same clear.

## Timing
- Reset values: out_e = 0, inst_e = 0, out_s = 0, valid_s = 0, ovf = 0; all internal registers 0; sh_full = 0.
- out_e, inst_e: 1-cycle latency west→east.
- WS psum: out_s is combinational from registered state. in_n at edge k appears in out_s after edge k, with valid_s high in the same cycle.
- OS weight: 1 cycle in_n→out_s. OS drain: the accumulator appears on out_s combinationally in the drain cycle.
- Reset asserted mid-operation: all state returns to reset values at that edge; no partial drain completes.
- A weight loaded into w_sh is usable for execute starting the cycle after the swap edge.

## Test plan
- Reset: hold reset=0 for 2 cycles with random inputs → all outputs 0; then the first load beat in_w=5 is absorbed (inst_e[0]=0) and the second load beat appears on inst_e[0]=1.
- WS ping-pong:
  - Load w=3, swap, then load w=−2 while executing a=4, in_n=10 → out_s = 22, valid_s=1.
  - Swap, then a=4, in_n=10 → out_s = 2.
- Simultaneous load+swap: w_sh=7, then load in_w=1 with swap in the same cycle → w_act=7, sh_full=1, w_sh=1, and the load is not forwarded east.
- OS accumulate+drain, 2-tile column:
  - Tile0 runs 3 executes a=2, w=3 → acc 18; tile1 runs 3 executes a=1, w=−1 → acc −3.
  - Two drains → bottom out_s sequence −3, 18; all acc end at 0.
- Saturation:
  - psum_bw=16, sat=1: preload acc 32760, then execute a=15, w=7 → acc 32767, ovf=1 and stays 1.
  - sat=0: same stimulus → acc −32671.
- Mode change: with acc≠0 and sh_full=1, toggle sel_mode while inst_w=0 → acc=0, sh_full=0, ovf=0, inst_e=0 next cycle.

Source files
------------

// File: rtl/mac_tile_db.sv
// Systolic MAC tile with ping-pong WS weights, OS accumulate/drain shift chain,
// and optional saturating accumulation with a sticky overflow flag.
module mac_tile_db #(
    parameter int unsigned bw      = 4,
    parameter int unsigned psum_bw = 16,
    parameter bit          sat     = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sel_mode,
    input  logic [bw-1:0]      in_w,
    output logic [bw-1:0]      out_e,
    input  logic [2:0]         inst_w,
    output logic [2:0]         inst_e,
    input  logic [psum_bw-1:0] in_n,
    output logic [psum_bw-1:0] out_s,
    output logic               valid_s,
    output logic               ovf
);

    localparam int unsigned PW = 2 * bw + 1;

    logic [bw-1:0]      a_q, a_d;
    logic [bw-1:0]      w_act_q, w_act_d;
    logic [bw-1:0]      w_sh_q, w_sh_d;
    logic               sh_full_q, sh_full_d;
    logic [psum_bw-1:0] c_q, c_d;
    logic [psum_bw-1:0] acc_q, acc_d;
    logic [2:0]         inst_q, inst_d;
    logic               mode_q, mode_d;
    logic               ovf_q, ovf_d;
    logic               valid_q, valid_d;

    logic               mode_chg;
    logic               absorb;
    logic [psum_bw-1:0] ws_prod, os_prod;
    logic [psum_bw:0]   ws_sum, os_sum;

    // Unsigned activation times signed weight, sign-extended to psum width.
    function automatic logic [psum_bw-1:0] mul_ext(input logic [bw-1:0] a,
                                                   input logic [bw-1:0] w);
        logic signed [PW-1:0] ae;
        logic signed [PW-1:0] we;
        logic signed [PW-1:0] p;
        ae = PW'($signed({1'b0, a}));
        we = PW'($signed(w));
        p  = ae * we;
        return psum_bw'(p);
    endfunction

    // Signed add; returns {overflow, result} with result saturated or wrapped.
    function automatic logic [psum_bw:0] add_acc(input logic [psum_bw-1:0] x,
                                                 input logic [psum_bw-1:0] y);
        logic [psum_bw:0]   s;
        logic               o;
        logic [psum_bw-1:0] r;
        s = {x[psum_bw-1], x} + {y[psum_bw-1], y};
        o = s[psum_bw] ^ s[psum_bw-1];
        r = s[psum_bw-1:0];
        if (o && sat) begin
            r = s[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
        end
        return {o, r};
    endfunction

    assign ws_prod = mul_ext(a_q, w_act_q);
    assign ws_sum  = add_acc(c_q, ws_prod);
    // OS accumulates the operands being registered this cycle, not the stored ones.
    assign os_prod = mul_ext(in_w, in_n[bw-1:0]);
    assign os_sum  = add_acc(acc_q, os_prod);

    // Next-state logic
    always_comb begin
        a_d       = a_q;
        w_act_d   = w_act_q;
        w_sh_d    = w_sh_q;
        sh_full_d = sh_full_q;
        c_d       = in_n;
        acc_d     = acc_q;
        inst_d    = inst_w;
        mode_d    = sel_mode;
        ovf_d     = ovf_q;
        valid_d   = 1'b0;
        absorb    = 1'b0;
        mode_chg  = (mode_q != sel_mode);

        if (inst_w[0] || inst_w[1]) begin
            a_d = in_w;
        end

        if (mode_chg) begin
            w_act_d   = '0;
            w_sh_d    = '0;
            sh_full_d = 1'b0;
            c_d       = '0;
            acc_d     = '0;
            inst_d    = '0;
            ovf_d     = 1'b0;
        end else if (!mode_q) begin
            valid_d = inst_w[1];
            // A swap frees the shadow bank, so a coincident load always lands.
            absorb  = inst_w[0] && (!sh_full_q || inst_w[2]);
            if (inst_w[2]) begin
                w_act_d   = w_sh_q;
                sh_full_d = 1'b0;
            end
            if (absorb) begin
                w_sh_d    = in_w;
                sh_full_d = 1'b1;
                inst_d[0] = 1'b0;
            end
            // The psum presented last cycle overflowed.
            if (valid_q && ws_sum[psum_bw]) begin
                ovf_d = 1'b1;
            end
        end else begin
            valid_d = inst_w[2];
            if (inst_w[1]) begin
                w_act_d = in_n[bw-1:0];
            end
            if (inst_w[2]) begin
                acc_d = in_n;
            end else if (inst_w[1]) begin
                acc_d = os_sum[psum_bw-1:0];
                if (os_sum[psum_bw]) begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    // State registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_q       <= '0;
            w_act_q   <= '0;
            w_sh_q    <= '0;
            sh_full_q <= 1'b0;
            c_q       <= '0;
            acc_q     <= '0;
            inst_q    <= '0;
            mode_q    <= 1'b0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            a_q       <= a_d;
            w_act_q   <= w_act_d;
            w_sh_q    <= w_sh_d;
            sh_full_q <= sh_full_d;
            c_q       <= c_d;
            acc_q     <= acc_d;
            inst_q    <= inst_d;
            mode_q    <= mode_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
        end
    end

    assign out_e   = a_q;
    assign inst_e  = inst_q;
    assign valid_s = valid_q;
    assign ovf     = ovf_q;
    assign out_s   = mode_q ? (inst_w[2] ? acc_q : psum_bw'(w_act_q))
                            : ws_sum[psum_bw-1:0];

endmodule

// File: tb/tb_mac_tile_db.sv
// Directed bench for mac_tile_db: WS vector table plus OS column, saturation
// and mode-change sequences.
module tb_mac_tile_db;

    logic clk;
    logic reset;
    always #5 clk = ~clk;

    // WS tile
    logic        ws_sel, ws_v, ws_o;
    logic [3:0]  ws_a, ws_e;
    logic [2:0]  ws_inst, ws_ie;
    logic [15:0] ws_n, ws_s;
    // OS column top / bottom (sat=1) and a wrapping tile (sat=0)
    logic        t_sel, t_v, t_o, b_v, b_o, r_v, r_o, chain;
    logic [3:0]  t_a, t_e, b_a, b_e, r_a, r_e;
    logic [2:0]  t_inst, t_ie, b_inst, b_ie, r_inst, r_ie;
    logic [15:0] t_n, t_s, b_n, b_n_eff, b_s, r_n, r_s;

    assign b_n_eff = chain ? t_s : b_n;

    mac_tile_db #(.bw(4), .psum_bw(16), .sat(1'b1)) u_ws (
        .clk(clk), .reset(reset), .sel_mode(ws_sel), .in_w(ws_a), .out_e(ws_e),
        .inst_w(ws_inst), .inst_e(ws_ie), .in_n(ws_n), .out_s(ws_s),
        .valid_s(ws_v), .ovf(ws_o));
    mac_tile_db #(.bw(4), .psum_bw(16), .sat(1'b1)) u_top (
        .clk(clk), .reset(reset), .sel_mode(t_sel), .in_w(t_a), .out_e(t_e),
        .inst_w(t_inst), .inst_e(t_ie), .in_n(t_n), .out_s(t_s),
        .valid_s(t_v), .ovf(t_o));
    mac_tile_db #(.bw(4), .psum_bw(16), .sat(1'b1)) u_bot (
        .clk(clk), .reset(reset), .sel_mode(1'b1), .in_w(b_a), .out_e(b_e),
        .inst_w(b_inst), .inst_e(b_ie), .in_n(b_n_eff), .out_s(b_s),
        .valid_s(b_v), .ovf(b_o));
    mac_tile_db #(.bw(4), .psum_bw(16), .sat(1'b0)) u_wrap (
        .clk(clk), .reset(reset), .sel_mode(1'b1), .in_w(r_a), .out_e(r_e),
        .inst_w(r_inst), .inst_e(r_ie), .in_n(r_n), .out_s(r_s),
        .valid_s(r_v), .ovf(r_o));

    int checks;
    int errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]  inst;
        logic [3:0]  a;
        logic [15:0] n;
        logic [15:0] s;
        logic        v;
        logic [2:0]  ie;
        logic [3:0]  e;
        logic        o;
    } vec_t;

    vec_t vecs[17];

    initial begin
        clk = 1'b0; reset = 1'b0; chain = 1'b0;
        ws_sel = 1'b0; ws_a = '0; ws_inst = '0; ws_n = '0;
        t_sel = 1'b1; t_a = '0; t_inst = '0; t_n = '0;
        b_a = '0; b_inst = '0; b_n = '0;
        r_a = '0; r_inst = '0; r_n = '0;
        checks = 0; errors = 0;

        //            inst    a      n         out_s     v     inst_e  out_e  ovf
        vecs[0]  = '{3'b001, 4'd5,  16'd0,    16'd0,    1'b0, 3'b000, 4'd5,  1'b0};
        vecs[1]  = '{3'b001, 4'd6,  16'd0,    16'd0,    1'b0, 3'b001, 4'd6,  1'b0};
        vecs[2]  = '{3'b100, 4'd0,  16'd0,    16'd30,   1'b0, 3'b100, 4'd6,  1'b0};
        vecs[3]  = '{3'b001, 4'd3,  16'd0,    16'd15,   1'b0, 3'b000, 4'd3,  1'b0};
        vecs[4]  = '{3'b100, 4'd0,  16'd0,    16'd9,    1'b0, 3'b100, 4'd3,  1'b0};
        vecs[5]  = '{3'b001, 4'd14, 16'd0,    16'd42,   1'b0, 3'b000, 4'd14, 1'b0};
        vecs[6]  = '{3'b010, 4'd4,  16'd10,   16'd22,   1'b1, 3'b010, 4'd4,  1'b0};
        vecs[7]  = '{3'b100, 4'd0,  16'd0,    16'hFFF8, 1'b0, 3'b100, 4'd4,  1'b0};
        vecs[8]  = '{3'b010, 4'd4,  16'd10,   16'd2,    1'b1, 3'b010, 4'd4,  1'b0};
        vecs[9]  = '{3'b001, 4'd7,  16'd0,    16'hFFF2, 1'b0, 3'b000, 4'd7,  1'b0};
        vecs[10] = '{3'b101, 4'd1,  16'd0,    16'd7,    1'b0, 3'b100, 4'd1,  1'b0};
        vecs[11] = '{3'b010, 4'd1,  16'd0,    16'd7,    1'b1, 3'b010, 4'd1,  1'b0};
        vecs[12] = '{3'b001, 4'd9,  16'd0,    16'd63,   1'b0, 3'b001, 4'd9,  1'b0};
        vecs[13] = '{3'b100, 4'd0,  16'd0,    16'd9,    1'b0, 3'b100, 4'd9,  1'b0};
        vecs[14] = '{3'b010, 4'd4,  16'd100,  16'd104,  1'b1, 3'b010, 4'd4,  1'b0};
        vecs[15] = '{3'b010, 4'd15, 16'h7FFF, 16'h7FFF, 1'b1, 3'b010, 4'd15, 1'b0};
        vecs[16] = '{3'b000, 4'd0,  16'd0,    16'd15,   1'b0, 3'b000, 4'd15, 1'b1};

        // Reset held for two edges under random inputs
        for (int i = 0; i < 2; i++) begin
            ws_sel  = 1'($urandom);
            ws_a    = 4'($urandom);
            ws_inst = 3'($urandom);
            ws_n    = 16'($urandom);
            step();
        end
        chk("rst_out_e", 32'(ws_e), 32'd0);
        chk("rst_inst_e", 32'(ws_ie), 32'd0);
        chk("rst_out_s", 32'(ws_s), 32'd0);
        chk("rst_valid", 32'(ws_v), 32'd0);
        chk("rst_ovf", 32'(ws_o), 32'd0);
        chk("rst_top_out_s", 32'(t_s), 32'd0);
        chk("rst_wrap_ovf", 32'(r_o), 32'd0);
        ws_sel = 1'b0; ws_a = '0; ws_inst = '0; ws_n = '0;
        reset = 1'b1;

        // WS vector table: load absorb/forward, ping-pong, load+swap, saturation
        for (int i = 0; i < 17; i++) begin
            ws_inst = vecs[i].inst;
            ws_a    = vecs[i].a;
            ws_n    = vecs[i].n;
            step();
            chk($sformatf("ws%0d_out_s", i), 32'(ws_s), 32'(vecs[i].s));
            chk($sformatf("ws%0d_valid", i), 32'(ws_v), 32'(vecs[i].v));
            chk($sformatf("ws%0d_inst_e", i), 32'(ws_ie), 32'(vecs[i].ie));
            chk($sformatf("ws%0d_out_e", i), 32'(ws_e), 32'(vecs[i].e));
            chk($sformatf("ws%0d_ovf", i), 32'(ws_o), 32'(vecs[i].o));
        end
        ws_inst = '0;

        // OS column: top a=2 w=3, bottom a=1 w=-1, three executes
        for (int k = 0; k < 3; k++) begin
            t_inst = 3'b010; t_a = 4'd2; t_n = 16'd3;
            b_inst = 3'b010; b_a = 4'd1; b_n = 16'h000F;
            step();
            if (k == 0) begin
                chk("os_top_weight_out", 32'(t_s), 32'd3);
                chk("os_bot_weight_out", 32'(b_s), 32'h000F);
                chk("os_exec_valid", 32'(b_v), 32'd0);
            end
        end
        // Drain bottom-first with top in_n tied to 0
        chain = 1'b1;
        t_inst = 3'b100; t_a = '0; t_n = 16'd0;
        b_inst = 3'b100; b_a = '0;
        #1;
        chk("drain1_bot", 32'(b_s), 32'h0000FFFD);
        chk("drain1_top", 32'(t_s), 32'd18);
        step();
        chk("drain_valid", 32'(b_v), 32'd1);
        chk("drain2_bot", 32'(b_s), 32'd18);
        chk("drain2_top", 32'(t_s), 32'd0);
        step();
        chk("drain3_bot_empty", 32'(b_s), 32'd0);
        chk("drain3_top_empty", 32'(t_s), 32'd0);
        chain = 1'b0;
        b_inst = '0;

        // Execute with drain: drain wins, acc loads in_n
        t_inst = 3'b110; t_a = 4'd5; t_n = 16'd5;
        step();
        t_inst = 3'b100; t_a = '0; t_n = 16'd0;
        #1;
        chk("exec_drain_acc", 32'(t_s), 32'd5);
        step();

        // Saturation vs wrap: preload 32760, then 15*7
        t_inst = 3'b100; t_n = 16'd32760;
        r_inst = 3'b100; r_n = 16'd32760;
        step();
        t_inst = 3'b010; t_a = 4'd15; t_n = 16'd7;
        r_inst = 3'b010; r_a = 4'd15; r_n = 16'd7;
        step();
        chk("sat_ovf", 32'(t_o), 32'd1);
        chk("wrap_ovf", 32'(r_o), 32'd1);
        t_inst = 3'b100; t_a = '0; t_n = 16'd0;
        r_inst = 3'b100; r_a = '0; r_n = 16'd0;
        #1;
        chk("sat_acc", 32'(t_s), 32'h7FFF);
        chk("wrap_acc", 32'(r_s), 32'h8061);
        step();
        t_inst = 3'b010; t_a = 4'd1; t_n = 16'd1;
        r_inst = '0;
        step();
        chk("sat_ovf_sticky", 32'(t_o), 32'd1);
        chk("wrap_ovf_sticky", 32'(r_o), 32'd1);
        t_inst = '0; t_a = '0; t_n = '0;

        // Mode change OS->WS with acc!=0 and ovf=1
        t_sel = 1'b0;
        step();
        chk("mc_ovf", 32'(t_o), 32'd0);
        chk("mc_inst_e", 32'(t_ie), 32'd0);
        chk("mc_acc", 32'(u_top.acc_q), 32'd0);
        chk("mc_ws_out_s", 32'(t_s), 32'd0);
        t_inst = 3'b001; t_a = 4'd3;
        step();
        chk("mc_pre_sh_full", 32'(u_top.sh_full_q), 32'd1);
        t_inst = '0; t_a = '0;
        t_sel = 1'b1;
        step();
        chk("mc_sh_full", 32'(u_top.sh_full_q), 32'd0);
        chk("mc_os_out_s", 32'(t_s), 32'd0);
        chk("mc_inst_e2", 32'(t_ie), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
